// File: rtl/decode_stage.sv
// MIPS decode stage: a two-entry (output + skid) elastic buffer holding raw instruction words.
// The decoded fields are derived from the held output word and read as zero when nothing is held.
module decode_stage #(
    parameter logic [31:0] PC_BASE_ADDR = 32'h80020000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [5:0]  out_opcode,
    output logic [5:0]  out_funct,
    output logic [4:0]  out_rs,
    output logic [4:0]  out_rt,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_shamt,
    output logic [31:0] out_imm,
    output logic [25:0] out_target,
    output logic [1:0]  out_type,
    output logic [4:0]  out_dest,
    output logic        out_reg_write,
    output logic        out_illegal,
    output logic [31:0] decoded_count
);

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        in_ready_q, in_ready_d;
    logic [31:0] count_q, count_d;
    logic        in_hs_s, out_hs_s;

    function automatic logic is_supported_i(input logic [5:0] op);
        case (op)
            6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
            6'h0E, 6'h0F, 6'h20, 6'h23, 6'h24, 6'h28, 6'h2B: is_supported_i = 1'b1;
            default:                                         is_supported_i = 1'b0;
        endcase
    endfunction

    assign in_hs_s  = in_valid & in_ready_q;
    assign out_hs_s = out_valid_q & out_ready;

    // Next-state for the output/skid buffer, ready flag and delivery counter.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        count_d      = out_hs_s ? count_q + 32'd1 : count_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // in_ready is low whenever the skid is full, so no input can arrive here
            if (out_hs_s) begin
                out_pc_d     = skid_pc_q;
                out_instr_d  = skid_instr_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b1;
            end
        end else if (in_hs_s) begin
            if (!out_valid_q || out_hs_s) begin
                out_valid_d = 1'b1;
                out_pc_d    = in_pc;
                out_instr_d = in_instr;
            end else begin
                skid_valid_d = 1'b1;
                skid_pc_d    = in_pc;
                skid_instr_d = in_instr;
            end
        end else if (out_hs_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        in_ready_d = ~skid_valid_d;
    end

    // State registers; asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q  <= 1'b0;
            out_pc_q     <= 32'd0;
            out_instr_q  <= 32'd0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= 32'd0;
            skid_instr_q <= 32'd0;
            in_ready_q   <= 1'b0;
            count_q      <= 32'd0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            in_ready_q   <= in_ready_d;
            count_q      <= count_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign decoded_count = count_q;

    // Field decode of the held word; everything idles at zero (PC at base) when empty.
    always_comb begin
        out_pc        = PC_BASE_ADDR;
        out_opcode    = 6'd0;
        out_funct     = 6'd0;
        out_rs        = 5'd0;
        out_rt        = 5'd0;
        out_rd        = 5'd0;
        out_shamt     = 5'd0;
        out_imm       = 32'd0;
        out_target    = 26'd0;
        out_type      = 2'b00;
        out_dest      = 5'd0;
        out_reg_write = 1'b0;
        out_illegal   = 1'b0;
        if (out_valid_q) begin
            out_pc     = out_pc_q;
            out_opcode = out_instr_q[31:26];
            out_funct  = out_instr_q[5:0];
            out_rs     = out_instr_q[25:21];
            out_rt     = out_instr_q[20:16];
            out_rd     = out_instr_q[15:11];
            out_shamt  = out_instr_q[10:6];
            out_target = out_instr_q[25:0];
            if (out_instr_q[31:26] == 6'h00) begin
                out_type = 2'b00;
            end else if (out_instr_q[31:26] == 6'h02 || out_instr_q[31:26] == 6'h03) begin
                out_type = 2'b10;
            end else begin
                out_type    = 2'b01;
                out_illegal = ~is_supported_i(out_instr_q[31:26]);
            end
            case (out_instr_q[31:26])
                6'h0C, 6'h0D, 6'h0E: out_imm = {16'd0, out_instr_q[15:0]};
                6'h0F:               out_imm = {out_instr_q[15:0], 16'h0000};
                default:             out_imm = {{16{out_instr_q[15]}}, out_instr_q[15:0]};
            endcase
            // Unsupported opcodes fall to the default and never write a register
            case (out_instr_q[31:26])
                6'h00: begin
                    out_dest      = out_instr_q[15:11];
                    out_reg_write = 1'b1;
                end
                6'h03: begin
                    out_dest      = 5'd31;
                    out_reg_write = 1'b1;
                end
                6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                6'h20, 6'h23, 6'h24: begin
                    out_dest      = out_instr_q[20:16];
                    out_reg_write = 1'b1;
                end
                default: begin
                    out_dest      = 5'd0;
                    out_reg_write = 1'b0;
                end
            endcase
        end else begin
            out_pc = PC_BASE_ADDR;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors push hand-computed expectations,
// a monitor pops and compares on every output handshake.
module tb_decode_stage;

    localparam logic [31:0] BASE = 32'h80020000;

    logic        clock, reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_pc, in_instr, out_pc, out_imm, decoded_count;
    logic [5:0]  out_opcode, out_funct;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt, out_dest;
    logic [25:0] out_target;
    logic [1:0]  out_type;
    logic        out_reg_write, out_illegal;

    decode_stage #(.PC_BASE_ADDR(BASE)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_funct(out_funct), .out_rs(out_rs), .out_rt(out_rt),
        .out_rd(out_rd), .out_shamt(out_shamt), .out_imm(out_imm), .out_target(out_target),
        .out_type(out_type), .out_dest(out_dest), .out_reg_write(out_reg_write),
        .out_illegal(out_illegal), .decoded_count(decoded_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [1:0]  typ;
        logic [4:0]  dest;
        logic        rw;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: compare the presented bundle whenever it is about to be handshaken.
    always begin
        @(negedge clock);
        #1;
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", out_pc, 32'hFFFFFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pc", out_pc, e.pc);
                chk("opcode", {26'd0, out_opcode}, {26'd0, e.instr[31:26]});
                chk("funct", {26'd0, out_funct}, {26'd0, e.instr[5:0]});
                chk("rs_rt_rd_shamt", {12'd0, out_rs, out_rt, out_rd, out_shamt}, {12'd0, e.instr[25:6]});
                chk("target", {6'd0, out_target}, {6'd0, e.instr[25:0]});
                chk("imm", out_imm, e.imm);
                chk("type", {30'd0, out_type}, {30'd0, e.typ});
                chk("dest", {27'd0, out_dest}, {27'd0, e.dest});
                chk("reg_write", {31'd0, out_reg_write}, {31'd0, e.rw});
                chk("illegal", {31'd0, out_illegal}, {31'd0, e.ill});
            end
        end
    end

    task automatic send(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] imm,
                        input logic [1:0] typ, input logic [4:0] dest, input logic rw, input logic ill);
        exp_t e;
        int   n;
        n = 0;
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n == 50) chk("accept_timeout", 32'd0, 32'd1);
        e.pc = pc; e.instr = instr; e.imm = imm; e.typ = typ; e.dest = dest; e.rw = rw; e.ill = ill;
        sb.push_back(e);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && (sb.size() != 0 || out_valid); i++) @(negedge clock);
        chk("drain_empty", sb.size(), 32'd0);
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = 32'd0; in_instr = 32'd0;
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_count", decoded_count, 32'd0);
        chk("rst_out_pc", out_pc, BASE);
        chk("rst_fields", {out_imm[15:0], out_dest, out_reg_write, out_type, out_illegal}, 32'd0);
        repeat (2) @(negedge clock);
        chk("rst_in_ready_held", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Decode vectors with the downstream always ready
        out_ready = 1'b1;
        send(32'h80020000, 32'h20080005, 32'h00000005, 2'b01, 5'd8,  1'b1, 1'b0);
        chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
        send(32'h80020004, 32'h3C01FFFF, 32'hFFFF0000, 2'b01, 5'd1,  1'b1, 1'b0);
        send(32'h80020008, 32'h3421FFFF, 32'h0000FFFF, 2'b01, 5'd1,  1'b1, 1'b0);
        send(32'h8002000C, 32'h2008FFFF, 32'hFFFFFFFF, 2'b01, 5'd8,  1'b1, 1'b0);
        send(32'h80020010, 32'h0C000010, 32'h00000010, 2'b10, 5'd31, 1'b1, 1'b0);
        send(32'h80020014, 32'hFC000000, 32'h00000000, 2'b01, 5'd0,  1'b0, 1'b1);
        send(32'h80020018, 32'h00221820, 32'h00001820, 2'b00, 5'd3,  1'b1, 1'b0);
        send(32'h8002001C, 32'hAC220004, 32'h00000004, 2'b01, 5'd0,  1'b0, 1'b0);
        send(32'h80020020, 32'h10220004, 32'h00000004, 2'b01, 5'd0,  1'b0, 1'b0);
        send(32'h80020024, 32'h08000100, 32'h00000100, 2'b10, 5'd0,  1'b0, 1'b0);
        send(32'h80020028, 32'h8C43FFFC, 32'hFFFFFFFC, 2'b01, 5'd3,  1'b1, 1'b0);
        send(32'h8002002C, 32'h30628000, 32'h00008000, 2'b01, 5'd2,  1'b1, 1'b0);
        send(32'h80020030, 32'h04010004, 32'h00000004, 2'b01, 5'd0,  1'b0, 1'b1);
        drain();
        chk("count_13", decoded_count, 32'd13);

        // Backpressure: output then skid fill, third instruction waits
        out_ready = 1'b0;
        send(32'h80021000, 32'h20090001, 32'h00000001, 2'b01, 5'd9,  1'b1, 1'b0);
        send(32'h80021004, 32'h200A0002, 32'h00000002, 2'b01, 5'd10, 1'b1, 1'b0);
        chk("skid_full_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1; in_pc = 32'h80021008; in_instr = 32'h200B0003;
        begin
            exp_t e;
            e.pc = 32'h80021008; e.instr = 32'h200B0003; e.imm = 32'h00000003;
            e.typ = 2'b01; e.dest = 5'd11; e.rw = 1'b1; e.ill = 1'b0;
            sb.push_back(e);
        end
        repeat (2) @(negedge clock);
        chk("held_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stable_pc", out_pc, 32'h80021000);
        chk("stable_dest", {27'd0, out_dest}, 32'd9);
        out_ready = 1'b1;
        @(negedge clock);
        chk("skid_drained_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
        drain();
        chk("count_16", decoded_count, 32'd16);

        // Flush with both registers full and an input offered
        out_ready = 1'b0;
        send(32'h80022000, 32'h200C0004, 32'h00000004, 2'b01, 5'd12, 1'b1, 1'b0);
        send(32'h80022004, 32'h200D0005, 32'h00000005, 2'b01, 5'd13, 1'b1, 1'b0);
        chk("pre_flush_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1; in_pc = 32'h80022008; in_instr = 32'h200E0006;
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_out_pc", out_pc, BASE);
        chk("flush_count", decoded_count, 32'd16);
        out_ready = 1'b1;
        send(32'h8002200C, 32'h200F0007, 32'h00000007, 2'b01, 5'd15, 1'b1, 1'b0);
        drain();
        chk("count_17", decoded_count, 32'd17);

        // Asynchronous reset between edges while a bundle is held
        out_ready = 1'b0;
        send(32'h80023000, 32'h20100008, 32'h00000008, 2'b01, 5'd16, 1'b1, 1'b0);
        chk("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("async_rst_count", decoded_count, 32'd0);
        chk("async_rst_out_pc", out_pc, BASE);
        chk("async_rst_rt", {27'd0, out_rt}, 32'd0);
        sb.delete();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rerelease_in_ready", {31'd0, in_ready}, 32'd1);

        // Counter wrap: preload just below the top, then deliver three bundles
        out_ready = 1'b1;
        force dut.count_q = 32'hFFFFFFFE;
        #1;
        release dut.count_q;
        @(negedge clock);
        chk("preload_count", decoded_count, 32'hFFFFFFFE);
        send(32'h80024000, 32'h20110009, 32'h00000009, 2'b01, 5'd17, 1'b1, 1'b0);
        drain();
        chk("count_top", decoded_count, 32'hFFFFFFFF);
        send(32'h80024004, 32'h2012000A, 32'h0000000A, 2'b01, 5'd18, 1'b1, 1'b0);
        drain();
        chk("count_wrap", decoded_count, 32'd0);
        send(32'h80024008, 32'h2013000B, 32'h0000000B, 2'b01, 5'd19, 1'b1, 1'b0);
        drain();
        chk("count_after_wrap", decoded_count, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter PC_BASE_ADDR, default 32'h80020000, value of out_pc while no instruction is held.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; asserted (0) clears state immediately, independent of clock.
REQ-004 flush  input  1  synchronous pipeline kill from branch/jump resolution.
REQ-005 in_valid  input  1  fetch side holds a valid instruction.
REQ-006 in_ready  output  1  decode can accept an instruction this cycle.
REQ-007 in_pc  input  32  address of in_instr.
REQ-008 in_instr  input  32  raw MIPS instruction word from the instruction register.
REQ-009 out_valid  output  1  decoded bundle valid.
REQ-010 out_ready  input  1  downstream (register read / execute) accepts the bundle.
REQ-011 out_pc  output  32  PC of the decoded instruction.
REQ-012 out_opcode, out_funct  output  6 each  instr[31:26], instr[5:0].
REQ-013 out_rs, out_rt, out_rd, out_shamt  output  5 each  instr[25:21], [20:16], [15:11], [10:6].
REQ-014 out_imm  output  32  extended immediate.
REQ-015 out_target  output  26  instr[25:0].
REQ-016 out_type  output  2  00 R, 01 I, 10 J.
REQ-017 out_dest  output  5  destination register; out_reg_write  output  1  destination written.
REQ-018 out_illegal  output  1  opcode not in the supported set.
REQ-019 decoded_count  output  32  number of bundles delivered downstream.

Function
REQ-020 Input handshake occurs when in_valid and in_ready are both 1 at a rising edge; output handshake when out_valid and out_ready are both 1.
REQ-021 Storage: one output register plus one skid register; in_ready SHALL equal (skid empty), registered, independent of in_valid.
REQ-022 Latency: an instruction accepted at edge N with the output register empty or draining SHALL appear on out_* after edge N (one cycle).
REQ-023 Accepted while the output register is full and out_ready=0: the instruction SHALL go to the skid register; in_ready SHALL be 0 from the next cycle.
REQ-024 Output handshake with skid full: the skid contents SHALL move to the output register and the skid SHALL empty; no input is accepted in that cycle (in_ready=0).
REQ-025 Output handshake with skid empty and an input handshake in the same cycle: the new instruction SHALL load the output register; out_valid SHALL stay 1.
REQ-026 Output handshake with no input handshake and skid empty: out_valid SHALL go to 0.
REQ-027 Ordering SHALL be strictly FIFO; no instruction is dropped or duplicated except by flush or reset.
REQ-028 Type: opcode 0 -> R; opcodes 0x02, 0x03 -> J; otherwise I.
REQ-029 Supported I-type opcodes: 0x04, 0x05, 0x08, 0x09, 0x0A, 0x0B, 0x0C, 0x0D, 0x0E, 0x0F, 0x20, 0x23, 0x24, 0x28, 0x2B; any other non-R, non-J opcode SHALL set out_illegal=1 and out_reg_write=0.
REQ-030 out_imm: zero-extend instr[15:0] for 0x0C/0x0D/0x0E; {instr[15:0],16'h0} for 0x0F; sign-extend otherwise (including R and J).
REQ-031 out_dest/out_reg_write: R -> rd,1; 0x03 (jal) -> 31,1; 0x08-0x0F, 0x20, 0x23, 0x24 -> rt,1; 0x04, 0x05, 0x28, 0x2B, 0x02, illegal -> 0,0.
REQ-032 Decode is computed from the stored instruction word, so all out_* fields SHALL be stable while out_valid=1 and out_ready=0.
REQ-033 flush=1 at an edge SHALL clear both valid bits; any input handshake in that cycle is discarded; in_ready SHALL be 1 the next cycle; decoded_count is unaffected except that a simultaneous output handshake still counts.
REQ-034 decoded_count SHALL increment by 1 on each output handshake and wrap from 32'hFFFFFFFF to 0.
REQ-035 When out_valid=0, out_pc SHALL hold PC_BASE_ADDR and all other decoded fields SHALL be 0.

Reset
REQ-036 While reset=0: out_valid=0, skid empty, in_ready=0, decoded_count=0, out_pc=PC_BASE_ADDR, all other outputs 0.
REQ-037 The first rising edge with reset=1 SHALL set in_ready=1; reset asserted mid-transfer SHALL discard held instructions without any output handshake.

Verification
REQ-038 in_instr=32'h20080005 (addi $8,$0,5), in_pc=32'h80020000, out_ready=1 -> next cycle out_type=01, out_dest=8, out_reg_write=1, out_imm=5, out_pc=32'h80020000.
REQ-039 in_instr=32'h3C01FFFF (lui) then 32'h3421FFFF (ori) -> out_imm=32'hFFFF0000, then 32'h0000FFFF; 32'h2008FFFF -> 32'hFFFFFFFF.
REQ-040 Stream 3 instructions with out_ready=0 -> first in output, second in skid, in_ready=0, third held; raise out_ready -> all three emerge in order, decoded_count=3.
REQ-041 in_instr=32'h0C000010 (jal) -> out_type=10, out_dest=31, out_target=26'h10; opcode 0x3F -> out_illegal=1, out_reg_write=0.
REQ-042 Both registers full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never appears.
REQ-043 reset=0 asserted between clock edges while out_valid=1 -> out_valid=0 immediately; decoded_count preloaded near 32'hFFFFFFFF via handshakes wraps to 0.
